// File: rtl/rv_arb_pkg.sv
// Shared types for the unified-memory arbiter between instruction fetch and data memory.
// The optional RV_ARB_PERF_EN build adds stall-cycle counters to rv_mem_arbiter.
package rv_arb_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RSP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/rv_arb_prio.sv
// Winner selection between fetch and data requests, with a starvation counter that
// forces a fetch win after STARVE_MAX consecutive data wins while fetch was waiting.
module rv_arb_prio
    import rv_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic dm_req,
    input  logic accept,
    output logic win_if,
    output logic win_dm
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        starve_cnt_d = starve_cnt_q;
        win_if       = if_req & (~dm_req | (starve_cnt_q == STARVE_LIM));
        win_dm       = dm_req & ~win_if;
        if (accept) begin
            if (win_if) begin
                starve_cnt_d = '0;
            end else if (if_req && (starve_cnt_q != STARVE_LIM)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one single-ported memory between the IF and DM pipeline stages: one outstanding
// transaction, req/gnt/rvalid to memory, routed responses and stalls. Optional: RV_ARB_PERF_EN.
module rv_mem_arbiter
    import rv_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef RV_ARB_PERF_EN
    output logic [31:0]       perf_stall_if_cnt,
    output logic [31:0]       perf_stall_dm_cnt,
`endif
    output logic              stall_if,
    output logic              stall_dm
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic accept;
    logic win_if;
    logic win_dm;

    // Grants are combinational from IDLE; suppressed while reset is asserted.
    assign accept = (state_q == ARB_IDLE) & (if_req | dm_req) & ~reset;

    rv_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .dm_req (dm_req),
        .accept (accept),
        .win_if (win_if),
        .win_dm (win_dm)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    state_d = ARB_REQ;
                    owner_d = win_dm ? OWN_DM : OWN_IF;
                    addr_d  = win_dm ? dm_addr : if_addr;
                    we_d    = win_dm & dm_we;
                    if (win_dm) begin
                        wdata_d = dm_wdata;
                    end
                end
            end
            ARB_REQ: begin
                if (mem_gnt) begin
                    state_d = ARB_RSP;
                end
            end
            ARB_RSP: begin
                if (mem_rvalid) begin
                    state_d = ARB_IDLE;
                    if (owner_q == OWN_DM) begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_gnt    = accept & win_if;
    assign dm_gnt    = accept & win_dm;
    assign mem_req   = (state_q == ARB_REQ);
    assign mem_we    = we_q & mem_req;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_rvalid_q;
    assign stall_dm  = dm_req & ~dm_rvalid_q;

`ifdef RV_ARB_PERF_EN
    logic [31:0] perf_if_q;
    logic [31:0] perf_dm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_q <= '0;
            perf_dm_q <= '0;
        end else begin
            perf_if_q <= perf_if_q + {31'b0, stall_if};
            perf_dm_q <= perf_dm_q + {31'b0, stall_dm};
        end
    end

    assign perf_stall_if_cnt = perf_if_q;
    assign perf_stall_dm_cnt = perf_dm_q;
`endif

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: reset/arbitration table, directed corner sequences
// and a randomized run, all compared against a transaction-level reference model.
module tb_rv_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata, dm_rdata;
    logic              mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              stall_if, stall_dm;
`ifdef RV_ARB_PERF_EN
    logic [31:0]       perf_stall_if_cnt, perf_stall_dm_cnt;
`endif

    always #5 clk = ~clk;

    rv_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
`ifdef RV_ARB_PERF_EN
        .perf_stall_if_cnt(perf_stall_if_cnt), .perf_stall_dm_cnt(perf_stall_dm_cnt),
`endif
        .stall_if(stall_if), .stall_dm(stall_dm)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference model: one pending transaction, its phase, and routed data.
    int          m_starve    = 0;
    bit          m_txn       = 0;
    bit          m_acc       = 0;
    bit          m_own_dm    = 0;
    bit          m_we        = 0;
    logic [31:0] m_addr      = '0;
    logic [31:0] m_wdata     = '0;
    bit          m_resp_due  = 0;
    bit          m_resp_dm   = 0;
    logic [31:0] m_if_rdata  = '0;
    logic [31:0] m_dm_rdata  = '0;
    logic [31:0] m_perf_if   = '0;
    logic [31:0] m_perf_dm   = '0;
    bit          last_if_gnt = 0;
    bit          last_dm_gnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit w_if, e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_mreq, e_stall_if, e_stall_dm;
        e_if_rv    = m_resp_due && !m_resp_dm;
        e_dm_rv    = m_resp_due && m_resp_dm;
        w_if       = if_req && (!dm_req || m_starve == STARVE_MAX);
        e_if_gnt   = !reset && !m_txn && w_if;
        e_dm_gnt   = !reset && !m_txn && dm_req && !w_if;
        e_mreq     = m_txn && !m_acc;
        e_stall_if = if_req && !e_if_rv;
        e_stall_dm = dm_req && !e_dm_rv;

        check("if_gnt", {31'b0, if_gnt}, {31'b0, e_if_gnt});
        check("dm_gnt", {31'b0, dm_gnt}, {31'b0, e_dm_gnt});
        check("if_rvalid", {31'b0, if_rvalid}, {31'b0, e_if_rv});
        check("dm_rvalid", {31'b0, dm_rvalid}, {31'b0, e_dm_rv});
        check("if_rdata", if_rdata, m_if_rdata);
        check("dm_rdata", dm_rdata, m_dm_rdata);
        check("mem_req", {31'b0, mem_req}, {31'b0, e_mreq});
        check("mem_we", {31'b0, mem_we}, {31'b0, e_mreq && m_we});
        if (e_mreq) begin
            check("mem_addr", mem_addr, m_addr);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        check("stall_if", {31'b0, stall_if}, {31'b0, e_stall_if});
        check("stall_dm", {31'b0, stall_dm}, {31'b0, e_stall_dm});
`ifdef RV_ARB_PERF_EN
        check("perf_if", perf_stall_if_cnt, m_perf_if);
        check("perf_dm", perf_stall_dm_cnt, m_perf_dm);
`endif
        m_perf_if   = reset ? 32'd0 : m_perf_if + {31'b0, e_stall_if};
        m_perf_dm   = reset ? 32'd0 : m_perf_dm + {31'b0, e_stall_dm};
        last_if_gnt = e_if_gnt;
        last_dm_gnt = e_dm_gnt;
        m_resp_due  = 0;

        if (reset) begin
            m_starve   = 0;
            m_txn      = 0;
            m_acc      = 0;
            m_if_rdata = '0;
            m_dm_rdata = '0;
        end else if (e_if_gnt || e_dm_gnt) begin
            if (e_if_gnt) m_starve = 0;
            else if (if_req && m_starve < STARVE_MAX) m_starve++;
            m_txn    = 1;
            m_acc    = 0;
            m_own_dm = e_dm_gnt;
            m_addr   = e_dm_gnt ? dm_addr : if_addr;
            m_we     = e_dm_gnt && dm_we;
            m_wdata  = dm_wdata;
        end else if (e_mreq && mem_gnt) begin
            m_acc = 1;
        end else if (m_txn && m_acc && mem_rvalid) begin
            m_resp_due = 1;
            m_resp_dm  = m_own_dm;
            if (m_own_dm) m_dm_rdata = mem_rdata;
            else          m_if_rdata = mem_rdata;
            m_txn = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        adv();
        reset = 0;
    endtask

    task automatic drive_random();
        if (!if_req || last_if_gnt) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = $urandom & ~32'd3;
        end
        if (!dm_req || last_dm_gnt) begin
            dm_req   = ($urandom_range(0, 3) != 0);
            dm_we    = ($urandom_range(0, 1) == 1);
            dm_addr  = $urandom & ~32'd3;
            dm_wdata = $urandom;
        end
        mem_rdata  = $urandom;
        mem_gnt    = ($urandom_range(0, 2) != 0);
        mem_rvalid = (m_txn && m_acc) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
        reset      = ($urandom_range(0, 499) == 0);
    endtask

    typedef struct {
        bit          if_req;
        bit          dm_req;
        bit          dm_we;
        logic [31:0] if_addr;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        bit          e_if_gnt;
        bit          e_dm_gnt;
        logic [31:0] e_mem_addr;
        bit          e_mem_we;
    } vec_t;

    vec_t vecs[5];
    bit   got_dm[10];
    bit   exp_dm[10];
    int   n_got;

    initial begin
        reset = 1;
        idle_inputs();
        adv();
        do_reset();

        // Arbitration from a fresh reset: single, simultaneous and absent requests.
        vecs[0] = '{0, 0, 0, 32'h0,   32'h0,   32'h0,    0, 0, 32'h0,   0};
        vecs[1] = '{1, 0, 0, 32'h104, 32'h0,   32'h0,    1, 0, 32'h104, 0};
        vecs[2] = '{0, 1, 0, 32'h0,   32'h208, 32'h0,    0, 1, 32'h208, 0};
        vecs[3] = '{0, 1, 1, 32'h0,   32'h30C, 32'hA5A5, 0, 1, 32'h30C, 1};
        vecs[4] = '{1, 1, 0, 32'h410, 32'h514, 32'h0,    0, 1, 32'h514, 0};
        for (int i = 0; i < 5; i++) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
            dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            step();
            check("tbl_if_gnt", {31'b0, if_gnt}, {31'b0, vecs[i].e_if_gnt});
            check("tbl_dm_gnt", {31'b0, dm_gnt}, {31'b0, vecs[i].e_dm_gnt});
            check("tbl_stall_if", {31'b0, stall_if}, {31'b0, vecs[i].if_req});
            adv();
            idle_inputs();
            step();
            check("tbl_mem_req", {31'b0, mem_req}, {31'b0, vecs[i].e_if_gnt | vecs[i].e_dm_gnt});
            check("tbl_mem_addr", mem_addr, vecs[i].e_mem_addr);
            check("tbl_mem_we", {31'b0, mem_we}, {31'b0, vecs[i].e_mem_we});
            adv();
            do_reset();
        end

        // IF-only fetch, fastest memory handshake plus one wait cycle before rvalid.
        if_req = 1; if_addr = 32'h10;
        step(); check("if_only_gnt", {31'b0, if_gnt}, 32'd1); adv();
        mem_gnt = 1;
        step(); check("if_only_mem_addr", mem_addr, 32'h10); check("if_only_mem_req", {31'b0, mem_req}, 32'd1); adv();
        mem_gnt = 0;
        step(); check("if_only_stall_wait", {31'b0, stall_if}, 32'd1); adv();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        step(); adv();
        mem_rvalid = 0; mem_rdata = '0;
        step();
        check("if_only_rvalid", {31'b0, if_rvalid}, 32'd1);
        check("if_only_rdata", if_rdata, 32'hDEADBEEF);
        check("if_only_stall_low", {31'b0, stall_if}, 32'd0);
        adv();
        step();
        check("if_only_stall_back", {31'b0, stall_if}, 32'd1);
        check("if_only_rdata_hold", if_rdata, 32'hDEADBEEF);
        adv();
        do_reset();

        // Collision: DM load wins, IF waits stalled and is served on the next IDLE.
        if_req = 1; if_addr = 32'h80; dm_req = 1; dm_addr = 32'h200;
        step(); check("col_dm_first", {31'b0, dm_gnt}, 32'd1); check("col_if_wait", {31'b0, if_gnt}, 32'd0); adv();
        dm_req = 0; mem_gnt = 1;
        step(); check("col_mem_addr_dm", mem_addr, 32'h200); check("col_stall_if1", {31'b0, stall_if}, 32'd1); adv();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
        step(); check("col_stall_if2", {31'b0, stall_if}, 32'd1); adv();
        mem_rvalid = 0;
        step();
        check("col_dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
        check("col_dm_rdata", dm_rdata, 32'hCAFE0001);
        check("col_if_gnt", {31'b0, if_gnt}, 32'd1);
        adv();
        mem_gnt = 1;
        step(); check("col_mem_addr_if", mem_addr, 32'h80); check("col_stall_if3", {31'b0, stall_if}, 32'd1); adv();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
        step(); adv();
        mem_rvalid = 0; if_req = 0;
        step(); check("col_if_rvalid", {31'b0, if_rvalid}, 32'd1); check("col_if_rdata", if_rdata, 32'h0BADF00D); adv();
        do_reset();

        // Store: write-enable and data reach memory; ack routed to DM.
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h1234;
        step(); check("st_gnt", {31'b0, dm_gnt}, 32'd1); adv();
        idle_inputs(); mem_gnt = 1;
        step();
        check("st_mem_we", {31'b0, mem_we}, 32'd1);
        check("st_mem_wdata", mem_wdata, 32'h1234);
        check("st_mem_addr", mem_addr, 32'h40);
        adv();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h5555AAAA;
        step(); adv();
        mem_rvalid = 0;
        step(); check("st_ack", {31'b0, dm_rvalid}, 32'd1); check("st_rdata", dm_rdata, 32'h5555AAAA); adv();
        do_reset();

        // Memory withholds mem_gnt; early mem_rvalid must be ignored.
        dm_req = 1; dm_addr = 32'h300;
        step(); adv();
        dm_req = 0; dm_addr = 32'h999; mem_rvalid = 1; mem_rdata = 32'h77777777;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_mem_req", {31'b0, mem_req}, 32'd1);
            check("hold_mem_addr", mem_addr, 32'h300);
            check("hold_no_rvalid", {31'b0, dm_rvalid}, 32'd0);
            adv();
        end
        mem_rvalid = 0; mem_gnt = 1;
        step(); adv();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h31415926;
        step(); adv();
        mem_rvalid = 0;
        step(); check("hold_final_rvalid", {31'b0, dm_rvalid}, 32'd1); adv();
        do_reset();

        // Reset while waiting for the response; the late mem_rvalid must be dropped.
        dm_req = 1; dm_addr = 32'h500;
        step(); adv();
        dm_req = 0; mem_gnt = 1;
        step(); adv();
        mem_gnt = 0; reset = 1;
        step(); adv();
        reset = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        step();
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
`ifdef RV_ARB_PERF_EN
        check("rst_perf_if", perf_stall_if_cnt, 32'd0);
        check("rst_perf_dm", perf_stall_dm_cnt, 32'd0);
`endif
        adv();
        mem_rvalid = 0;
        step(); check("rst_late_rvalid", {31'b0, dm_rvalid}, 32'd0); check("rst_late_rdata", dm_rdata, 32'd0); adv();
        do_reset();

        // Starvation: both held continuously gives DM x STARVE_MAX, then IF, repeating.
        for (int i = 0; i < 10; i++) exp_dm[i] = ((i % (STARVE_MAX + 1)) != STARVE_MAX);
        n_got = 0;
        for (int cyc = 0; cyc < 200 && n_got < 10; cyc++) begin
            if_req = 1; dm_req = 1; dm_we = 0;
            if (last_if_gnt) if_addr = $urandom & ~32'd3;
            if (last_dm_gnt) dm_addr = $urandom & ~32'd3;
            mem_gnt = 1; mem_rvalid = m_txn && m_acc; mem_rdata = $urandom;
            step();
            if (if_gnt || dm_gnt) begin
                got_dm[n_got] = dm_gnt;
                n_got++;
            end
            adv();
        end
        check("starve_grant_count", n_got, 32'd10);
        for (int i = 0; i < n_got; i++) begin
            check($sformatf("starve_order_%0d_is_dm", i), {31'b0, got_dm[i]}, {31'b0, exp_dm[i]});
        end
        do_reset();

        // Randomized traffic, memory latency and occasional resets against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_random();
            step();
            adv();
        end
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
Shares one single-ported unified memory between the pipeline's instruction-fetch stage (IF) and its data-memory stage (DM). Arbitrates requests, runs a req/gnt/rvalid handshake to memory, routes responses back, and generates stall signals. The IF-side stall feeds the PC/IF-ID enables; the DM-side stall freezes the pipeline. Sits between the core pipeline and the memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive DM wins with IF waiting before IF is forced to win (1..15)

Ports:
clk  in  1  clock
reset  in  1  reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted (1-cycle pulse)
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  data request accepted (1-cycle pulse)
dm_rvalid  out  1  load data / store ack valid (1-cycle pulse)
dm_rdata  out  DATA_W  load data
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  memory response (loads and stores)
mem_rdata  in  DATA_W  memory read data
stall_if  out  1  IF stage must hold
stall_dm  out  1  DM stage must hold

Behaviour:
- Clock is clk; reset is synchronous, active-high, named reset. Single clock domain.
- FSM: ARB_IDLE, ARB_REQ, ARB_RSP. One transaction outstanding at most.
- ARB_IDLE: if any request, select winner, latch addr/we/wdata/owner, pulse winner's gnt in the same cycle, go ARB_REQ. Otherwise stay.
- Winner: DM by default. IF wins if only IF requests, or if both request and starve_cnt == STARVE_MAX.
- starve_cnt: +1 when DM wins while if_req=1, saturating at STARVE_MAX; cleared when IF wins.
- ARB_REQ: mem_req=1, driven from latched registers. Stays until mem_gnt=1, then goes ARB_RSP. mem_rvalid in ARB_REQ is ignored.
- ARB_RSP: mem_req=0. When mem_rvalid=1: copy mem_rdata to owner's rdata, pulse owner's rvalid, go ARB_IDLE. Write response data goes to dm_rdata unchanged.
- Minimum transaction: 3 cycles (IDLE→REQ with mem_gnt same cycle→RSP with rvalid). No back-to-back: IDLE is always visited.
- if_rdata/dm_rdata are registered and hold their last value between pulses.
- stall_if = if_req & ~if_rvalid; stall_dm = dm_req & ~dm_rvalid (combinational).
- Requester may change or drop its request after gnt; the latched copy is used.
- Reset values: state ARB_IDLE, starve_cnt 0, mem_req/mem_we 0, mem_addr/mem_wdata 0, gnt/rvalid 0, rdata 0. Stall outputs then follow their requests.
- Reset mid-transaction aborts to ARB_IDLE. mem_req drops in the next cycle. A late mem_rvalid seen in ARB_IDLE is dropped.
- Simultaneous requests in IDLE: exactly one gnt. The loser stays stalled until it is served.

Optional Feature:
RV_ARB_PERF_EN. Defined: extra outputs perf_stall_if_cnt[31:0] and perf_stall_dm_cnt[31:0]. Each counts cycles with its stall output high, wraps at 2^32, and clears on reset. Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rv_arb_pkg: arb_state_t enum {ARB_IDLE, ARB_REQ, ARB_RSP}; owner_t enum {OWN_IF, OWN_DM}; localparam STARVE_W = 4.
- Sub-module rv_arb_prio: starvation counter plus winner select. Inputs if_req, dm_req, accept strobe; outputs win_if, win_dm.

Test Plan:
- IF-only: if_req=1, if_addr=0x10; mem_gnt on first REQ cycle; mem_rvalid 2 cycles later with 0xDEADBEEF → if_gnt at cycle 0, mem_req at cycle 1 with mem_addr=0x10, if_rvalid with if_rdata=0xDEADBEEF, stall_if low in that cycle only.
- Collision: if_req and dm_req (load 0x200) asserted together → dm_gnt first; after the DM response, IF is granted on the next IDLE; stall_if stays high throughout.
- Starvation with STARVE_MAX=4: dm_req and if_req held continuously → grant order DM,DM,DM,DM,IF,DM…
- Store: dm_we=1, addr 0x40, wdata 0x1234 → mem_we=1, mem_wdata=0x1234; dm_rvalid pulses on mem_rvalid.
- mem_gnt held low for 5 cycles → mem_req and address stable for all 5 cycles; no rvalid is emitted.
- reset during ARB_RSP, then mem_rvalid arrives → no rvalid pulse, FSM in ARB_IDLE, outputs at reset values; with RV_ARB_PERF_EN, counters read 0.
